// File: rtl/reset_out_sequencer.sv
// Outbound active-low board reset generator: holds the pin low for a fixed
// width, waits a recovery interval, then reports ready for the next request.
module reset_out_sequencer #(
   parameter int ASSERT_CYCLES   = 400,
   parameter int RECOVERY_CYCLES = 4000,
   parameter int CNT_W           = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       reset_request,
   output logic       pin_reset_out_n,
   output logic       ready,
   output logic       busy,
   output logic [7:0] event_count
);

   generate
      if (ASSERT_CYCLES < 1 || RECOVERY_CYCLES < 1) begin : g_bad_cycles
         $error("reset_out_sequencer: ASSERT_CYCLES and RECOVERY_CYCLES must be >= 1");
      end
      if ((ASSERT_CYCLES - 1) >= (1 << CNT_W) || (RECOVERY_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
         $error("reset_out_sequencer: CNT_W too narrow for the configured cycle counts");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RECOVER = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ASSERT_LAST   = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= ST_ASSERT;
         cnt             <= '0;
         pin_reset_out_n <= 1'b0;
         ready           <= 1'b0;
         busy            <= 1'b1;
         event_count     <= 8'd0;
      end else begin
         case (state)
            ST_ASSERT: begin
               if (cnt == ASSERT_LAST) begin
                  state           <= ST_RECOVER;
                  cnt             <= '0;
                  pin_reset_out_n <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            // A request on the terminal-count edge takes priority over going ready.
            ST_RECOVER: begin
               if (reset_request) begin
                  state           <= ST_ASSERT;
                  cnt             <= '0;
                  pin_reset_out_n <= 1'b0;
                  event_count     <= sat_inc(event_count);
               end else if (cnt == RECOVERY_LAST) begin
                  state <= ST_READY;
                  cnt   <= '0;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_READY: begin
               if (reset_request) begin
                  state           <= ST_ASSERT;
                  cnt             <= '0;
                  pin_reset_out_n <= 1'b0;
                  ready           <= 1'b0;
                  busy            <= 1'b1;
                  event_count     <= sat_inc(event_count);
               end
            end
            default: begin
               state           <= ST_ASSERT;
               cnt             <= '0;
               pin_reset_out_n <= 1'b0;
               ready           <= 1'b0;
               busy            <= 1'b1;
            end
         endcase
      end
   end

endmodule
